// File: rtl/adder_core.sv
// Registered ripple-carry adder: WIDTH full-adder cells feeding a one-cycle
// output stage with carry-out, signed overflow and zero flags.
module adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic [WIDTH-1:0] out_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign carry[0] = cin;

    // One full-adder cell per bit; each carry feeds the next cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_d[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout_d = carry[WIDTH];
    assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    assign zero_d = ~|sum_d;

    // Zero is taken from the fresh sum so it lines up with out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_adder_core.sv
// Bench for adder_core at WIDTH=1 and WIDTH=8: a table of vectors plus a
// mid-stream reset sequence, with expectations queued and compared after each edge.
module tb_adder_core;

    typedef struct {
        int         idx;
        int         w;
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] eOut;
        logic       eCout;
        logic       eOvf;
        logic       eZero;
    } vec_t;

    localparam int NVEC = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic [0:0] out1;
    logic       cout1, ovf1, zero1;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] out8;
    logic       cout8, ovf8, zero8;

    int   tests = 0;
    int   fails = 0;
    vec_t sbQ[$];
    vec_t vecs[NVEC];

    adder_core #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
        .out(out1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    adder_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
        .out(out8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int idx, input int w, input logic r,
                                input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic [7:0] eo, input logic ec, input logic ev,
                                input logic ez);
        vec_t v;
        v.idx = idx; v.w = w; v.rst = r; v.a = a; v.b = b; v.cin = c;
        v.eOut = eo; v.eCout = ec; v.eOvf = ev; v.eZero = ez;
        return v;
    endfunction

    // Independent 8-bit reference using integer addition and sign rules.
    function automatic vec_t model8(input int idx, input logic [7:0] a,
                                    input logic [7:0] b, input logic c);
        logic [8:0] s;
        logic       v;
        s = {1'b0, a} + {1'b0, b} + {8'd0, c};
        v = (a[7] == b[7]) && (s[7] != a[7]);
        return mk(idx, 8, 1'b0, a, b, c, s[7:0], s[8], v, s[7:0] == 8'd0);
    endfunction

    task automatic cmp(input int idx, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL vec%0d %s: got %h expected %h", idx, field, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst;
        if (v.w == 1) begin
            a1   = v.a[0:0];
            b1   = v.b[0:0];
            cin1 = v.cin;
        end else begin
            a8   = v.a;
            b8   = v.b;
            cin8 = v.cin;
        end
        sbQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t v;
        @(posedge clk);
        #1;
        if (sbQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard: got empty queue expected one entry");
        end else begin
            v = sbQ.pop_front();
            if (v.w == 1) begin
                cmp(v.idx, "out",  {7'd0, out1},  v.eOut);
                cmp(v.idx, "cout", {7'd0, cout1}, {7'd0, v.eCout});
                cmp(v.idx, "ovf",  {7'd0, ovf1},  {7'd0, v.eOvf});
                cmp(v.idx, "zero", {7'd0, zero1}, {7'd0, v.eZero});
            end else begin
                cmp(v.idx, "out",  out8,          v.eOut);
                cmp(v.idx, "cout", {7'd0, cout8}, {7'd0, v.eCout});
                cmp(v.idx, "ovf",  {7'd0, ovf8},  {7'd0, v.eOvf});
                cmp(v.idx, "zero", {7'd0, zero8}, {7'd0, v.eZero});
            end
        end
    endtask

    task automatic runCycle(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        // WIDTH=1 truth table: {a,b,cin} -> out, cout, ovf, zero
        vecs[0]  = mk(0,  1, 0, 8'h00, 8'h00, 0, 8'h0, 0, 0, 1);
        vecs[1]  = mk(1,  1, 0, 8'h00, 8'h00, 1, 8'h1, 0, 1, 0);
        vecs[2]  = mk(2,  1, 0, 8'h00, 8'h01, 0, 8'h1, 0, 0, 0);
        vecs[3]  = mk(3,  1, 0, 8'h00, 8'h01, 1, 8'h0, 1, 0, 1);
        vecs[4]  = mk(4,  1, 0, 8'h01, 8'h00, 0, 8'h1, 0, 0, 0);
        vecs[5]  = mk(5,  1, 0, 8'h01, 8'h00, 1, 8'h0, 1, 0, 1);
        vecs[6]  = mk(6,  1, 0, 8'h01, 8'h01, 0, 8'h0, 1, 1, 1);
        vecs[7]  = mk(7,  1, 0, 8'h01, 8'h01, 1, 8'h1, 1, 0, 0);
        vecs[8]  = mk(8,  1, 0, 8'h03, 8'hFF, 0, 8'h0, 1, 1, 1);
        vecs[9]  = mk(9,  8, 0, 8'h03, 8'hFF, 0, 8'h02, 1, 0, 0);
        vecs[10] = mk(10, 8, 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 0);
        vecs[11] = mk(11, 8, 0, 8'hFF, 8'h00, 1, 8'h00, 1, 0, 1);
        vecs[12] = mk(12, 8, 0, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0, 0);
        for (int i = 13; i < NVEC; i++)
            vecs[i] = model8(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             1'($urandom_range(0, 1)));

        runCycle(mk(100, 8, 1, 8'h5A, 8'hC3, 1, 8'h00, 0, 0, 1));
        runCycle(mk(101, 1, 1, 8'h01, 8'h01, 1, 8'h00, 0, 0, 1));

        // Table vectors go out on consecutive edges, so each check also proves 1-cycle latency.
        for (int i = 0; i < NVEC; i++)
            runCycle(vecs[i]);

        runCycle(mk(200, 8, 1, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, 1));
        runCycle(mk(201, 8, 0, 8'hFF, 8'hFF, 0, 8'hFE, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_core.md
ADDER_CORE -- requirements
Module: adder_core

Interface
REQ-001 SHALL have parameter WIDTH, default 1, operand/sum bit width (legal range 1..64).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 SHALL have port b  input  WIDTH  operand B, unsigned or two's complement.
REQ-006 SHALL have port cin  input  1  carry-in, added at bit 0.
REQ-007 SHALL have port out  output  WIDTH  registered sum bits, a+b+cin modulo 2^WIDTH.
REQ-008 SHALL have port cout  output  1  registered carry out of MSB.
REQ-009 SHALL have port ovf  output  1  registered signed overflow, carry into MSB XOR carry out of MSB.
REQ-010 SHALL have port zero  output  1  registered flag, high when out is all zeros.

Function
REQ-011 SHALL compute sum bits from a chain of WIDTH 1-bit full-adder cells: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin.
REQ-012 SHALL use a ripple-carry chain, one cell per bit, with no operator-level '+' for the sum path.
REQ-013 SHALL register out, cout, ovf and zero on every rising clk edge when rst is low.
REQ-014 SHALL have latency exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-015 SHALL accept new operands every cycle, with no handshake and no stall.
REQ-016 SHALL derive zero from the newly computed sum, in the same cycle as out, never from the previous registered value.
REQ-017 SHALL produce, for WIDTH=1, out = a^b^cin and cout = majority(a,b,cin).
REQ-018 SHALL wrap on full overflow: all-ones + all-ones + 1 gives out = all-ones, cout = 1.
REQ-019 SHALL treat inputs driven as wider constants by truncating them to the low WIDTH bits at the port, so a value of 3 on a 1-bit port equals 1.
REQ-020 SHALL leave unknown input bits to propagate as unknown only through the affected bit and carry path, with no other state corruption.

Reset
REQ-021 SHALL, on a rising clk edge with rst high, set out = 0, cout = 0, ovf = 0 and zero = 1.
REQ-022 SHALL give rst priority over the computation at that edge; operands present during reset are discarded.
REQ-023 SHALL output the sum of operands sampled at the first edge after rst deasserts, one cycle later.
REQ-024 SHALL make outputs before the first reset edge undefined; the bench SHALL apply reset for at least 1 cycle first.

Verification
REQ-025 SHALL pass with WIDTH=1: all 8 {a,b,cin} combos, e.g. 0,1,0 -> out 1 cout 0; 1,1,0 -> out 0 cout 1; 1,0,1 -> out 0 cout 1; 1,1,1 -> out 1 cout 1; 0,0,1 -> out 1 cout 0.
REQ-026 SHALL pass with WIDTH=1: a driven 3, b driven -1, cin 0 -> out 0, cout 1 (truncation per REQ-019).
REQ-027 SHALL pass with WIDTH=8: a=0x03, b=0xFF, cin=0 -> out 0x02, cout 1, ovf 0, zero 0.
REQ-028 SHALL pass with WIDTH=8: a=0x7F, b=0x01, cin=0 -> out 0x80, cout 0, ovf 1; a=0xFF, b=0x00, cin=1 -> out 0x00, cout 1, zero 1.
REQ-029 SHALL pass a reset-mid-stream case: rst high for one edge while a=0xFF, b=0xFF -> out 0, cout 0, zero 1; next edge with rst low gives out 0xFE, cout 1.
REQ-030 SHALL pass back-to-back operands on consecutive edges, each result appearing exactly one cycle after its operands.
